// File: rtl/mux_share_arb.sv
// Round-robin owner of the shared 2:1 datapath mux (d0/d1 -> dout, select sel).
// Latency: a request seen in IDLE is granted after one edge; handover between owners takes no idle cycle.
// Backpressure: a master keeps its level req high until it sees its gnt; the owner holds the mux while req stays high.
//
// Ports: clk, rst_n (async active-low); req0/req1 level requests; d0/d1 data inputs;
//        gnt0/gnt1 one-hot ownership; sel registered select; dout = sel ? d1 : d0;
//        dvalid = owner's request still high; preempt = one-cycle pulse on forced revoke.
// Optional: define ARB_HOLD_LIMIT_EN to revoke an owner after HOLD_MAX consecutive cycles
//           while the other master waits. Without it preempt is tied low.
module mux_share_arb #(
    parameter int WIDTH    = 32,
    parameter int HOLD_MAX = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0,
    input  logic             req1,
    input  logic [WIDTH-1:0] d0,
    input  logic [WIDTH-1:0] d1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             sel,
    output logic [WIDTH-1:0] dout,
    output logic             dvalid,
    output logic             preempt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    state_t state_q, state_d;
    logic   last_q,  last_d;   // most recently granted master
    logic   sel_q,   sel_d;

`ifdef ARB_HOLD_LIMIT_EN
    logic [7:0] cnt_q, cnt_d;
    logic       preempt_q, preempt_d;
    logic       hold_hit;

    assign hold_hit = (cnt_q == 8'(HOLD_MAX - 1));
`endif

    always_comb begin
        state_d = state_q;
`ifdef ARB_HOLD_LIMIT_EN
        preempt_d = 1'b0;
`endif
        unique case (state_q)
            IDLE: begin
                if (req0 && req1)  state_d = last_q ? OWN0 : OWN1;
                else if (req0)     state_d = OWN0;
                else if (req1)     state_d = OWN1;
            end
            OWN0: begin
                // Owner releasing hands straight to a waiting peer, no IDLE bubble.
                if (!req0) begin
                    state_d = req1 ? OWN1 : IDLE;
                end
`ifdef ARB_HOLD_LIMIT_EN
                else if (req1 && hold_hit) begin
                    state_d   = OWN1;
                    preempt_d = 1'b1;
                end
`endif
            end
            OWN1: begin
                if (!req1) begin
                    state_d = req0 ? OWN0 : IDLE;
                end
`ifdef ARB_HOLD_LIMIT_EN
                else if (req0 && hold_hit) begin
                    state_d   = OWN0;
                    preempt_d = 1'b1;
                end
`endif
            end
            default: state_d = IDLE;
        endcase

        // last and sel only move on entry into an owner state; IDLE keeps sel.
        last_d = last_q;
        sel_d  = sel_q;
        if (state_d == OWN0 && state_q != OWN0) begin
            last_d = 1'b0;
            sel_d  = 1'b0;
        end else if (state_d == OWN1 && state_q != OWN1) begin
            last_d = 1'b1;
            sel_d  = 1'b1;
        end

`ifdef ARB_HOLD_LIMIT_EN
        // Counts cycles already spent by the current owner, saturating.
        cnt_d = cnt_q;
        if (state_d != IDLE && state_d != state_q) begin
            cnt_d = 8'd0;
        end else if (state_q != IDLE && cnt_q != 8'hFF) begin
            cnt_d = cnt_q + 8'd1;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            last_q  <= 1'b1;   // first tie after reset goes to master 0
            sel_q   <= 1'b0;
`ifdef ARB_HOLD_LIMIT_EN
            cnt_q     <= 8'd0;
            preempt_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            sel_q   <= sel_d;
`ifdef ARB_HOLD_LIMIT_EN
            cnt_q     <= cnt_d;
            preempt_q <= preempt_d;
`endif
        end
    end

    assign gnt0   = (state_q == OWN0);
    assign gnt1   = (state_q == OWN1);
    assign sel    = sel_q;
    assign dout   = sel_q ? d1 : d0;
    assign dvalid = (gnt0 & req0) | (gnt1 & req1);
`ifdef ARB_HOLD_LIMIT_EN
    assign preempt = preempt_q;
`else
    assign preempt = 1'b0;
`endif

endmodule
